// File: rtl/dsp_sched_pkg.sv
// dsp_sched_pkg: op encodings and DSP48E2 ALUMODE/OPMODE control words
// for the shared TWO24 SIMD logic unit.
package dsp_sched_pkg;
    typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_XNOR = 2'b11} op_t;

    localparam logic [3:0] ALUMODE_AND  = 4'b1100;
    localparam logic [3:0] ALUMODE_OR   = 4'b1100;
    localparam logic [3:0] ALUMODE_XOR  = 4'b0100;
    localparam logic [3:0] ALUMODE_XNOR = 4'b0101;
    localparam logic [8:0] OPMODE_AND   = 9'b000110011;
    localparam logic [8:0] OPMODE_OR    = 9'b000111011;
    localparam logic [8:0] OPMODE_XOR   = 9'b000110011;
    localparam logic [8:0] OPMODE_XNOR  = 9'b000110011;

    function automatic logic [12:0] op_to_ctrl(input op_t op);
        return op == OP_OR   ? {ALUMODE_OR, OPMODE_OR}
             : op == OP_XOR  ? {ALUMODE_XOR, OPMODE_XOR}
             : op == OP_XNOR ? {ALUMODE_XNOR, OPMODE_XNOR}
             :                 {ALUMODE_AND, OPMODE_AND};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after ptr, wrapping;
// returns it as one-hot grant plus index.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
        if (valid) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/dsp_logic_sched.sv
// dsp_logic_sched: round-robin scheduler packing same-op requests onto the two
// 24-bit SIMD lanes of a shared DSP48E2 logic unit, returning tagged results.
module dsp_logic_sched
    import dsp_sched_pkg::*;
#(
    parameter int width   = 24,
    parameter int NUM_REQ = 4,
    parameter int DSP_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [width*NUM_REQ-1:0] req_a,
    input  logic [width*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [width*NUM_REQ-1:0] resp_y,
    output logic [3:0]               dsp_alumode,
    output logic [8:0]               dsp_opmode,
    output logic [29:0]              dsp_a,
    output logic [17:0]              dsp_b,
    output logic [47:0]              dsp_c,
    input  logic [47:0]              dsp_p
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]           rr_ptr, p_idx, s_idx;
    logic [NUM_REQ-1:0]      p_grant;
    logic                    p_valid, s_found;
    op_t                     p_op;
    logic signed [width-1:0] pa, pb, sa, sb;
    logic [23:0]             a0, b0, a1, b1;
    logic [DSP_LAT:0]        tv0, tv1;
    logic [IW-1:0]           tid0 [DSP_LAT+1];
    logic [IW-1:0]           tid1 [DSP_LAT+1];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (p_grant),
        .idx   (p_idx),
        .valid (p_valid)
    );

    // Lane 1 takes the next same-op requester after P, since both lanes share ALUMODE/OPMODE.
    always_comb begin : pair
        int j;
        j       = 0;
        p_op    = op_t'(req_op[int'(p_idx)*2 +: 2]);
        s_found = 1'b0;
        s_idx   = '0;
        for (int k = 1; k < NUM_REQ; k++) begin
            j = (int'(p_idx) + k) % NUM_REQ;
            if (p_valid && !s_found && req_valid[j] && req_op[j*2 +: 2] == p_op) begin
                s_found = 1'b1;
                s_idx   = IW'(j);
            end
        end
        req_ready = p_grant;
        if (s_found) req_ready[s_idx] = 1'b1;
        pa = req_a[int'(p_idx)*width +: width];
        pb = req_b[int'(p_idx)*width +: width];
        sa = req_a[int'(s_idx)*width +: width];
        sb = req_b[int'(s_idx)*width +: width];
        a0 = p_valid ? 24'(pa) : '0;
        b0 = p_valid ? 24'(pb) : '0;
        a1 = s_found ? 24'(sa) : '0;
        b1 = s_found ? 24'(sb) : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr                    <= '0;
            {dsp_alumode, dsp_opmode} <= {ALUMODE_AND, OPMODE_AND};
            {dsp_a, dsp_b}            <= '0;
            dsp_c                     <= '0;
            tv0                       <= '0;
            tv1                       <= '0;
            for (int i = 0; i <= DSP_LAT; i++) begin
                tid0[i] <= '0;
                tid1[i] <= '0;
            end
            resp_valid <= '0;
            resp_y     <= '0;
        end else begin
            if (p_valid) rr_ptr <= p_idx == IW'(NUM_REQ-1) ? '0 : p_idx + 1'b1;
            {dsp_alumode, dsp_opmode} <= p_valid ? op_to_ctrl(p_op) : {ALUMODE_AND, OPMODE_AND};
            {dsp_a, dsp_b}            <= {b1, b0};
            dsp_c                     <= {a1, a0};
            // Tag stage DSP_LAT lines up with dsp_p for the same issue.
            tv0[0]  <= p_valid;
            tid0[0] <= p_idx;
            tv1[0]  <= s_found;
            tid1[0] <= s_idx;
            for (int i = 1; i <= DSP_LAT; i++) begin
                tv0[i]  <= tv0[i-1];
                tid0[i] <= tid0[i-1];
                tv1[i]  <= tv1[i-1];
                tid1[i] <= tid1[i-1];
            end
            resp_valid <= '0;
            if (tv0[DSP_LAT]) begin
                resp_valid[tid0[DSP_LAT]]                    <= 1'b1;
                resp_y[int'(tid0[DSP_LAT])*width +: width]   <= dsp_p[0 +: width];
            end
            if (tv1[DSP_LAT]) begin
                resp_valid[tid1[DSP_LAT]]                    <= 1'b1;
                resp_y[int'(tid1[DSP_LAT])*width +: width]   <= dsp_p[24 +: width];
            end
        end
    end
endmodule
